// File: rtl/kanagawa_sdp_ram_stream_reader_if.sv
// Command, RAM read-port and output-stream signals of the SDP RAM stream reader.
// The reader connects through 'slave'; the surrounding logic or a bench connects through 'master'.
interface kanagawa_sdp_ram_stream_reader_if #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int COUNT_WIDTH = 6
);
  logic                   cmd_valid_in;
  logic                   cmd_ready_out;
  logic [ADDR_WIDTH-1:0]  cmd_addr_in;
  logic [COUNT_WIDTH-1:0] cmd_count_in;
  logic                   ram_rd_en_out;
  logic [ADDR_WIDTH-1:0]  ram_rd_addr_out;
  logic [WIDTH-1:0]       ram_rd_data_in;
  logic                   data_valid_out;
  logic                   data_ready_in;
  logic [WIDTH-1:0]       data_out;
  logic                   data_last_out;
  logic                   busy_out;

  modport slave (
    input  cmd_valid_in, cmd_addr_in, cmd_count_in, ram_rd_data_in, data_ready_in,
    output cmd_ready_out, ram_rd_en_out, ram_rd_addr_out, data_valid_out, data_out,
    data_last_out, busy_out
  );

  modport master (
    output cmd_valid_in, cmd_addr_in, cmd_count_in, ram_rd_data_in, data_ready_in,
    input  cmd_ready_out, ram_rd_en_out, ram_rd_addr_out, data_valid_out, data_out,
    data_last_out, busy_out
  );
endinterface

// File: rtl/kanagawa_sdp_ram_stream_reader.sv
// Burst read initiator for the SDP RAM tile: issues reads, absorbs the RAM latency, streams words out.
// Define KANAGAWA_STREAM_READER_ASSERT_EN to compile in simulation assertions.
module kanagawa_sdp_ram_stream_reader #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 2,
  parameter int COUNT_WIDTH  = ADDR_WIDTH + 1
) (
  input logic clk,
  input logic rst,
  kanagawa_sdp_ram_stream_reader_if.slave bus
);

  localparam int BUF_DEPTH = READ_LATENCY + 2;
  localparam int OUT_W     = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W     = $clog2(BUF_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [COUNT_WIDTH-1:0]  rem_q, rem_d;
  logic [OUT_W-1:0]        outst_q, outst_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [READ_LATENCY-1:0] tag_q, tag_d;
  logic [WIDTH-1:0]        fifo_data_q [BUF_DEPTH];
  logic [WIDTH-1:0]        fifo_data_d [BUF_DEPTH];
  logic                    fifo_last_q [BUF_DEPTH];
  logic                    fifo_last_d [BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0]        fifo_cnt_q, fifo_cnt_d;

  logic fifo_valid, cmd_fire, issue, pop, exit_vld;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    outst_d     = outst_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_cnt_d  = fifo_cnt_q;
    vld_d       = '0;
    tag_d       = '0;

    fifo_valid = (fifo_cnt_q != '0);
    cmd_fire   = (state_q == IDLE) && bus.cmd_valid_in && !rst;
    // outstanding counts every word issued but not yet popped, so the buffer cannot overflow
    issue      = (state_q == ISSUE) && (outst_q < OUT_W'(BUF_DEPTH)) && !rst;
    pop        = fifo_valid && bus.data_ready_in && !rst;
    exit_vld   = vld_q[READ_LATENCY-1];

    case (state_q)
      IDLE: begin
        if (cmd_fire && (bus.cmd_count_in != '0)) begin
          addr_d  = bus.cmd_addr_in;
          rem_d   = bus.cmd_count_in;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue) begin
          addr_d = (addr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : addr_q + ADDR_WIDTH'(1);
          rem_d  = rem_q - COUNT_WIDTH'(1);
          if (rem_q == COUNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && fifo_last_q[rd_ptr_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    vld_d[0] = issue;
    tag_d[0] = (rem_q == COUNT_WIDTH'(1));
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end

    // the last pipeline stage lines up with the RAM returning that read's data
    if (exit_vld) begin
      fifo_data_d[wr_ptr_q] = bus.ram_rd_data_in;
      fifo_last_d[wr_ptr_q] = tag_q[READ_LATENCY-1];
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    case ({exit_vld, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + OUT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - OUT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({issue, pop})
      2'b10:   outst_d = outst_q + OUT_W'(1);
      2'b01:   outst_d = outst_q - OUT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      outst_q    <= '0;
      vld_q      <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      outst_q     <= outst_d;
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
    end
  end

  // outputs are forced to their reset values while rst is high
  assign bus.cmd_ready_out   = (state_q == IDLE) && !rst;
  assign bus.ram_rd_en_out   = issue;
  assign bus.ram_rd_addr_out = rst ? '0 : addr_q;
  assign bus.data_valid_out  = fifo_valid && !rst;
  assign bus.data_out        = rst ? '0 : fifo_data_q[rd_ptr_q];
  assign bus.data_last_out   = fifo_valid && !rst && fifo_last_q[rd_ptr_q];
  assign bus.busy_out        = (state_q != IDLE) && !rst;

`ifdef KANAGAWA_STREAM_READER_ASSERT_EN
  a_cmd_addr: assert property (@(posedge clk) disable iff (rst)
    cmd_fire |-> (32'(bus.cmd_addr_in) < DEPTH))
    else $error("cmd_addr_in out of range at handshake");
  a_hold: assert property (@(posedge clk) disable iff (rst)
    (bus.data_valid_out && !bus.data_ready_in) |=>
    (bus.data_valid_out && $stable(bus.data_out) && $stable(bus.data_last_out)))
    else $error("output word changed while stalled");
  a_outst: assert property (@(posedge clk) disable iff (rst)
    32'(outst_q) <= BUF_DEPTH)
    else $error("outstanding exceeds buffer depth");
  a_rd_x: assert property (@(posedge clk) disable iff (rst)
    exit_vld |-> !$isunknown(bus.ram_rd_data_in))
    else $error("unknown RAM data on a valid return");
`else
  // no checking logic in this build
`endif

endmodule

// File: tb/tb_kanagawa_sdp_ram_stream_reader.sv
// Scoreboard bench for kanagawa_sdp_ram_stream_reader: random RAM contents, reference bursts
// computed from start address/count, and a separate latency-1 instance.
module tb_kanagawa_sdp_ram_stream_reader;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int AW = 5;
  localparam int CW = 6;
  localparam int RL = 2;
  localparam int BUF_DEPTH = RL + 2;

  logic clk;
  logic rst;
  int   cyc = 0;

  kanagawa_sdp_ram_stream_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus0();
  kanagawa_sdp_ram_stream_reader_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) bus1();

  kanagawa_sdp_ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .READ_LATENCY(RL), .COUNT_WIDTH(CW)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  kanagawa_sdp_ram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .READ_LATENCY(1), .COUNT_WIDTH(CW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               exp_cyc;
  } exp_t;

  exp_t             sb[$];
  int               addrq[$];
  int               checks = 0;
  int               errors = 0;
  bit               rdy_rand = 0;
  int               last_pop_cyc = -1;
  int               pops = 0;
  int               outst = 0;
  bit               busy_exp = 0;
  bit               prev_stall = 0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rq0 [0:4];
  logic [WIDTH-1:0] rq1 [0:4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // RAM tiles: a read sampled in cycle t shows up on rd_data during cycle t+latency
  initial begin
    for (int j = 0; j < 5; j++) begin
      rq0[j] = '0;
      rq1[j] = '0;
    end
    bus0.ram_rd_data_in = '0;
    bus1.ram_rd_data_in = '0;
    forever begin
      @(negedge clk);
      for (int j = 4; j > 0; j--) begin
        rq0[j] = rq0[j-1];
        rq1[j] = rq1[j-1];
      end
      rq0[0] = bus0.ram_rd_en_out ? mem[bus0.ram_rd_addr_out] : $urandom();
      rq1[0] = bus1.ram_rd_en_out ? mem[bus1.ram_rd_addr_out] : $urandom();
      bus0.ram_rd_data_in = rq0[RL];
      bus1.ram_rd_data_in = rq1[1];
    end
  end

  initial begin
    bus0.data_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus0.data_ready_in = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor for the main instance
  initial begin
    exp_t e;
    bit   pop;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("reset_outputs", {bus0.cmd_ready_out, bus0.ram_rd_en_out, bus0.data_valid_out,
            bus0.data_last_out, bus0.busy_out, bus0.ram_rd_addr_out, bus0.data_out}, 64'd0);
        chk("reset_outputs_l1", {bus1.cmd_ready_out, bus1.ram_rd_en_out, bus1.data_valid_out,
            bus1.data_last_out, bus1.busy_out, bus1.ram_rd_addr_out, bus1.data_out}, 64'd0);
        sb.delete();
        addrq.delete();
        outst = 0;
        busy_exp = 0;
        prev_stall = 0;
      end else begin
        chk("busy", bus0.busy_out, busy_exp);
        if (prev_stall) begin
          chk("hold_valid", bus0.data_valid_out, 1);
          chk("hold_word", {bus0.data_last_out, bus0.data_out}, {prev_last, prev_data});
        end
        if (bus0.ram_rd_en_out) begin
          chk("outstanding_bound", outst < BUF_DEPTH, 1);
          if (addrq.size() == 0) chk("unexpected_read", 1, 0);
          else chk("rd_addr", bus0.ram_rd_addr_out, addrq.pop_front());
          outst++;
        end
        pop = bus0.data_valid_out && bus0.data_ready_in;
        if (pop) begin
          if (sb.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            e = sb.pop_front();
            chk("data", bus0.data_out, e.data);
            chk("last", bus0.data_last_out, e.last);
            if (e.exp_cyc >= 0) chk("word_cycle", cyc, e.exp_cyc);
            if (e.last) begin
              last_pop_cyc = cyc;
              busy_exp = 0;
            end
          end
          outst--;
          pops++;
        end
        if (bus0.cmd_valid_in && bus0.cmd_ready_out && bus0.cmd_count_in != '0) busy_exp = 1;
        prev_stall = bus0.data_valid_out && !bus0.data_ready_in;
        prev_data  = bus0.data_out;
        prev_last  = bus0.data_last_out;
      end
    end
  end

  task automatic send_cmd(input int addr, input int count, input bit timed, output int acc);
    bit   got = 0;
    exp_t e;
    @(posedge clk);
    #1;
    bus0.cmd_valid_in = 1'b1;
    bus0.cmd_addr_in  = AW'(addr);
    bus0.cmd_count_in = CW'(count);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus0.cmd_ready_out) begin
        got = 1;
        break;
      end
    end
    chk("cmd_accept", got, 1);
    acc = cyc;
    for (int k = 0; k < count; k++) begin
      e.data    = mem[(addr + k) % DEPTH];
      e.last    = (k == count - 1);
      e.exp_cyc = timed ? acc + 2 + RL + k : -1;
      sb.push_back(e);
      addrq.push_back((addr + k) % DEPTH);
    end
    @(posedge clk);
    #1;
    bus0.cmd_valid_in = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus0.busy_out) begin
        done = 1;
        break;
      end
    end
    chk(name, done, 1);
  endtask

  initial begin
    int acc, acc_b, p0, k;
    bit got;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
    bus0.cmd_valid_in = 0; bus0.cmd_addr_in = '0; bus0.cmd_count_in = '0;
    bus1.cmd_valid_in = 0; bus1.cmd_addr_in = '0; bus1.cmd_count_in = '0;
    bus1.data_ready_in = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_reset", bus0.cmd_ready_out, 1);

    // basic and wrap-around bursts with the consumer always ready
    send_cmd(3, 5, 1, acc);
    wait_done("basic_done");
    send_cmd(30, 4, 1, acc);
    wait_done("wrap_done");

    // second command held pending while the first drains
    send_cmd(5, 3, 1, acc);
    send_cmd(9, 2, 1, acc_b);
    chk("b2b_accept_cycle", acc_b, last_pop_cyc + 1);
    wait_done("b2b_done");

    // zero-length command
    send_cmd(7, 0, 1, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_cmd_ready", bus0.cmd_ready_out, 1);
      chk("zero_no_output", {bus0.data_valid_out, bus0.busy_out, bus0.ram_rd_en_out}, 0);
    end

    // backpressure burst
    rdy_rand = 1;
    send_cmd($urandom_range(0, DEPTH - 1), 16, 0, acc);
    wait_done("bp_done");

    // random bursts, some longer than the RAM
    for (int n = 0; n < 10; n++) begin
      rdy_rand = 1'($urandom_range(0, 1));
      send_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), !rdy_rand, acc);
      wait_done("rand_done");
    end

    // reset in the middle of a burst
    rdy_rand = 1;
    p0 = pops;
    send_cmd($urandom_range(0, DEPTH - 1), 10, 0, acc);
    got = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (pops >= p0 + 3) begin
        got = 1;
        break;
      end
    end
    chk("midburst_pops", got, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_rand = 0;
    send_cmd(0, 2, 1, acc);
    wait_done("post_reset_done");

    // latency-1 instance
    @(posedge clk);
    #1;
    bus1.cmd_valid_in = 1'b1;
    bus1.cmd_addr_in  = '0;
    bus1.cmd_count_in = CW'(3);
    @(negedge clk);
    chk("l1_cmd_ready", bus1.cmd_ready_out, 1);
    acc = cyc;
    @(posedge clk);
    #1;
    bus1.cmd_valid_in = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus1.data_valid_out) begin
        chk("l1_data", bus1.data_out, mem[k % DEPTH]);
        chk("l1_last", bus1.data_last_out, (k == 2));
        chk("l1_cycle", cyc, acc + 3 + k);
        k++;
      end
    end
    chk("l1_word_count", k, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/kanagawa_sdp_ram_stream_reader.md
# kanagawa_sdp_ram_stream_reader

Read-side initiator for the simple dual-port RAM tile. It accepts a command (start address, word count), issues back-to-back reads on the tile's read port, and absorbs the fixed RAM read latency. Returned words are presented on a valid/ready stream with full backpressure and an end-of-burst marker. It sits between a consumer pipeline and the `rd_*` side of a RAM tile; the write side of the tile is driven elsewhere.

## Interface
Parameters:
- `WIDTH`, 32, data word width.
- `DEPTH`, 32, RAM depth in words; need not be a power of two.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, RAM address width.
- `READ_LATENCY`, 2, cycles from `ram_rd_en_out` to valid `ram_rd_data_in`. 1 = tile without output register, 2 = with. Legal range 1..4.
- `COUNT_WIDTH`, `ADDR_WIDTH+1`, width of the burst length field.

Ports (one clock; reset is synchronous and active-high; clock `clk`, reset `rst`):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `cmd_valid_in` in 1: command valid.
- `cmd_ready_out` out 1: command accepted when valid && ready.
- `cmd_addr_in` in ADDR_WIDTH: first address; must be < DEPTH.
- `cmd_count_in` in COUNT_WIDTH: number of words to read.
- `ram_rd_en_out` out 1: tile read enable.
- `ram_rd_addr_out` out ADDR_WIDTH: tile read address.
- `ram_rd_data_in` in WIDTH: tile read data.
- `data_valid_out` out 1: output word valid.
- `data_ready_in` in 1: consumer accepts the word.
- `data_out` out WIDTH: output word.
- `data_last_out` out 1: marks the final word of the burst.
- `busy_out` out 1: a command is in progress.

## Operation
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: `cmd_ready_out`=1.
    - Handshake with count≠0: latch addr/count, go to ISSUE.
    - Count=0: command is consumed, no reads are issued, and the FSM stays in IDLE.
  - ISSUE: issue one read per cycle while `outstanding < BUF_DEPTH`. Each issue decrements the remaining count. The issue of the final word moves the FSM to DRAIN.
  - DRAIN: no issues. When the word carrying `data_last_out` is popped, go to IDLE.
- Address increments by 1 per issue and wraps to 0 after DEPTH-1. Counts greater than DEPTH re-read from the start address cyclically.
- `BUF_DEPTH` = READ_LATENCY+2. Output buffer is a circular FIFO of BUF_DEPTH entries.
- `outstanding` counter (width `$clog2(BUF_DEPTH+1)`):
  - +1 on issue.
  - −1 on pop (`data_valid_out && data_ready_in`).
  - Both in the same cycle: unchanged.
  - The counter never exceeds BUF_DEPTH, so the buffer can never overflow.
- A valid shift register of READ_LATENCY stages tracks in-flight reads and carries a last tag. When a stage exits, `ram_rd_data_in` and the tag are written into the buffer in that same cycle.
- Output comes from the buffer head. `data_out` and `data_last_out` hold stable while valid && !ready.
- `busy_out` = (state≠IDLE).

## Timing
- Reset: state IDLE, counters/pointers 0, valid pipeline cleared.
- Output values while `rst`=1:
  - `cmd_ready_out`=0.
  - `ram_rd_en_out`=0, `data_valid_out`=0, `data_last_out`=0, `busy_out`=0.
  - `ram_rd_addr_out`=0, `data_out`=0.
- `cmd_ready_out`=1 from the first cycle after `rst` deasserts.
- Command accepted in cycle c:
  - First `ram_rd_en_out` is in cycle c+1.
  - First `data_valid_out` is in cycle c+2+READ_LATENCY (c+4 at default).
- With `data_ready_in` held high, throughput is 1 word/cycle with no bubbles.
- Back-to-back commands: the next command is accepted one cycle after the last pop.
- Backpressure: when `outstanding` reaches BUF_DEPTH, issuing stalls. Issuing resumes the cycle after a pop.
- Reset mid-burst: all in-flight and buffered data is discarded. RAM data returning after reset is ignored.

## Configuration
- `KANAGAWA_STREAM_READER_ASSERT_EN` defined: simulation assertions are compiled in. The following are errors:
  - `cmd_addr_in` ≥ DEPTH at handshake.
  - `data_valid_out` dropping, or `data_out` changing, while valid && !ready.
  - `outstanding` > BUF_DEPTH.
  - X on `ram_rd_data_in` when a pipeline stage exits valid.
- Undefined: no assertion logic, with identical functional behaviour.

## Test plan
- Basic read: RAM preloaded with mem[i]=i. Command addr=3, count=5, ready held high → 5 consecutive reads at addr 3..7; data 3,4,5,6,7 on consecutive cycles starting 4 cycles after accept; last on 7; busy falls after the pop of 7.
- Wrap: DEPTH=32, addr=30, count=4 → read addresses 30,31,0,1; outputs mem[30],mem[31],mem[0],mem[1].
- Backpressure: count=16, ready toggling 1-0-0-1 random → all 16 words delivered in order, no loss/duplication; `outstanding` never exceeds 4; `ram_rd_en_out` stalls while buffer full.
- Zero count: command count=0 → accepted in one cycle, no `ram_rd_en_out`, no output, `cmd_ready_out` stays 1.
- Reset mid-burst: count=10, assert `rst` after 3 pops → outputs at reset values, late RAM data ignored; new command addr=0, count=2 → exactly mem[0],mem[1] delivered.
- Latency 1: READ_LATENCY=1, addr=0, count=3, ready high → first valid 3 cycles after accept, 1 word/cycle.
